if_fetch: RTL

IF_FETCH -- requirements
Module: if_fetch

---
 rtl/if_fetch_pkg.sv | 16 +
 rtl/if_fetch_queue.sv | 71 +++++++
 rtl/if_fetch.sv | 114 +++++++++++
 3 files changed

// File: rtl/if_fetch_pkg.sv
// Shared defines for the instruction fetch slice: bus widths, chip-enable levels
// and the default reset fetch address.
package if_fetch_pkg;

    localparam int InstAddrBus = 32;
    localparam int InstBus     = 64;

    localparam logic [InstBus-1:0]     ZeroDoubleWord   = 64'h0;
    localparam logic                   ChipEnable       = 1'b1;
    localparam logic                   ChipDisable      = 1'b0;
    localparam logic [InstAddrBus-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // Queue entry layout: {pc, inst}
    localparam int QEntryW = InstAddrBus + InstBus;

endpackage

// File: rtl/if_fetch_queue.sv
// if_queue: small circular FIFO holding fetched {pc, inst} pairs.
// Clear empties it in one edge; head reads as zero when empty.
module if_queue #(
    parameter int DEPTH = 2,
    parameter int DW    = 96,
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW   = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] push_data,
    output logic [DW-1:0] head_data,
    output logic [CW-1:0] count
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] mem_d [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (clear) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            // When full, push and pop share a slot: the old head is read out
            // before the edge and the new tail lands in its place.
            if (push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign head_data = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
    assign count     = count_q;

endmodule

// File: rtl/if_fetch.sv
// Instruction fetch: pc register, ROM interface and a small queue toward decode.
// IF_ALIGN_CHECK_EN adds misalign_o and rejects redirects to non 8-byte targets.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [InstAddrBus-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int                     QDEPTH   = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   rom_ce,
    output logic [InstAddrBus-1:0] rom_addr,
    input  logic [InstBus-1:0]     rom_inst,
    input  logic                   id_ready,
    output logic                   id_valid,
    output logic [InstAddrBus-1:0] id_pc,
    output logic [InstBus-1:0]     id_inst,
    input  logic                   flush_i,
    input  logic [InstAddrBus-1:0] new_pc_i,
    input  logic                   branch_i,
    input  logic [InstAddrBus-1:0] branch_target_i
`ifdef IF_ALIGN_CHECK_EN
    ,
    output logic                   misalign_o
`endif
);

    localparam int QAW = $clog2(QDEPTH);
    localparam int QCW = QAW + 1;
    localparam logic [QCW-1:0] QDEPTH_C = QCW'(QDEPTH);

    generate
        if (QDEPTH != 2 && QDEPTH != 4) begin : g_bad_qdepth
            $error("if_fetch: QDEPTH must be 2 or 4");
        end
    endgenerate

    logic [InstAddrBus-1:0] pc_q, pc_d;
    logic [InstAddrBus-1:0] redirect_target;
    logic                   redirect;
    logic                   fetch;
    logic                   deq;
    logic [QCW-1:0]         count;
    logic [QEntryW-1:0]     head;

    // Exception flush outranks a branch redirect.
    assign redirect        = flush_i | branch_i;
    assign redirect_target = flush_i ? new_pc_i : branch_target_i;

    assign id_valid = !rst && (count != '0);
    assign id_pc    = id_valid ? head[QEntryW-1:InstBus] : '0;
    assign id_inst  = id_valid ? head[InstBus-1:0]       : ZeroDoubleWord;

    always_comb begin
        deq   = id_valid && id_ready && !redirect;
        fetch = !rst && !redirect && ((count < QDEPTH_C) || deq);
        pc_d  = pc_q;
        if (redirect) begin
`ifdef IF_ALIGN_CHECK_EN
            if (redirect_target[2:0] == 3'b000) begin
                pc_d = redirect_target;
            end
`else
            pc_d = redirect_target & ~32'd7;
`endif
        end else if (fetch) begin
            pc_d = pc_q + 32'd8;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

`ifdef IF_ALIGN_CHECK_EN
    logic misalign_q, misalign_d;

    always_comb begin
        misalign_d = redirect && (redirect_target[2:0] != 3'b000);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= misalign_d;
        end
    end

    assign misalign_o = misalign_q && !rst;
`endif

    assign rom_ce   = fetch ? ChipEnable : ChipDisable;
    assign rom_addr = rst ? RESET_PC : pc_q;

    if_queue #(
        .DEPTH (QDEPTH),
        .DW    (QEntryW)
    ) u_queue (
        .clk       (clk),
        .rst       (rst),
        .clear     (redirect),
        .push      (fetch),
        .pop       (deq),
        .push_data ({pc_q, rom_inst}),
        .head_data (head),
        .count     (count)
    );

endmodule
